// File: rtl/rs_dec_syndrome_calc.sv
// Syndrome generator for the CIRC RS decoder: S_j = r(alpha^j), j=0..3, over GF(2^8)/0x11D.
// Bytes arrive highest degree first; one Horner step per accepted byte, results held until the next frame completes.
module rs_dec_syndrome_calc #(
    parameter int N_BYTES = 32
) (
    input  logic       i_clk,
    input  logic       i_resb,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_sof,
    output logic [7:0] o_s0,
    output logic [7:0] o_s1,
    output logic [7:0] o_s2,
    output logic [7:0] o_s3,
    output logic       o_synd_sync,
    output logic       o_nonzero,
    output logic       o_busy,
    output logic       o_frame_err
);

    localparam int CW = $clog2(N_BYTES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N_BYTES - 1);

    // Multiply by alpha^n: n repeated shift-and-reduce steps modulo 0x11D.
    function automatic logic [7:0] mul_alpha_pow(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int k = 0; k < n; k++) begin
            y = {y[6:0], 1'b0} ^ (y[7] ? 8'h1D : 8'h00);
        end
        return y;
    endfunction

    logic [3:0][7:0] acc_reg;
    logic [3:0][7:0] acc_next;
    logic [3:0][7:0] synd_reg;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;
    logic            sync_reg;
    logic            nonzero_reg;
    logic            busy_reg;
    logic            frame_err_reg;

    logic idle;
    logic is_first;
    logic is_step;
    logic is_last;
    logic is_stray;

    assign idle     = (cnt_reg == '0);
    assign is_first = i_valid & i_sof;
    assign is_step  = i_valid & ~i_sof & ~idle;
    assign is_stray = i_valid & ~i_sof & idle;
    assign is_last  = is_step & (cnt_reg == LAST_CNT);

    // A start-of-frame byte seeds every accumulator directly (zero seed times alpha^j is zero).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_acc
            assign acc_next[gi] = is_first ? i_data
                                           : (mul_alpha_pow(acc_reg[gi], gi) ^ i_data);
        end
    endgenerate

    always_comb begin
        cnt_next = cnt_reg;
        if (is_first) begin
            cnt_next = CW'(1);
        end else if (is_step) begin
            cnt_next = is_last ? '0 : (cnt_reg + CW'(1));
        end
    end

    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) begin
            acc_reg       <= '0;
            synd_reg      <= '0;
            cnt_reg       <= '0;
            sync_reg      <= 1'b0;
            nonzero_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (is_first || is_step) begin
                acc_reg <= acc_next;
            end
            if (is_last) begin
                synd_reg    <= acc_next;
                nonzero_reg <= |acc_next;
            end
            cnt_reg       <= cnt_next;
            sync_reg      <= is_last;
            busy_reg      <= (cnt_next != '0);
            frame_err_reg <= (is_first & ~idle) | is_stray;
        end
    end

    assign o_s0        = synd_reg[0];
    assign o_s1        = synd_reg[1];
    assign o_s2        = synd_reg[2];
    assign o_s3        = synd_reg[3];
    assign o_synd_sync = sync_reg;
    assign o_nonzero   = nonzero_reg;
    assign o_busy      = busy_reg;
    assign o_frame_err = frame_err_reg;

endmodule

// File: tb/tb_rs_dec_syndrome_calc.sv
// Directed bench for rs_dec_syndrome_calc (N_BYTES=32) with hand-computed syndromes.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_rs_dec_syndrome_calc;

    localparam int N = 32;

    logic       clk;
    logic       resb;
    logic [7:0] data;
    logic       valid;
    logic       sof;
    logic [7:0] s0, s1, s2, s3;
    logic       synd_sync;
    logic       nonzero;
    logic       busy;
    logic       frame_err;

    int n_checks;
    int n_pass;
    int sync_pulses;

    logic [7:0] frame [N];

    rs_dec_syndrome_calc #(.N_BYTES(N)) dut (
        .i_clk       (clk),
        .i_resb      (resb),
        .i_data      (data),
        .i_valid     (valid),
        .i_sof       (sof),
        .o_s0        (s0),
        .o_s1        (s1),
        .o_s2        (s2),
        .o_s3        (s3),
        .o_synd_sync (synd_sync),
        .o_nonzero   (nonzero),
        .o_busy      (busy),
        .o_frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (synd_sync === 1'b1) sync_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) frame[i] = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic first);
        data  = d;
        sof   = first;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        sof   = 1'b0;
        data  = 8'h00;
    endtask

    // Sends frame[lo..hi]; random idle cycles are inserted only between bytes of a frame.
    task automatic send_part(input int lo, input int hi, input int gap_max);
        int gap;
        for (int i = lo; i <= hi; i++) begin
            gap = (i == 0 || gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send_byte(frame[i], i == 0);
        end
    endtask

    task automatic check_synd(input string tag, input logic [31:0] exp, input logic exp_nz);
        check({tag, "_sync"}, {31'd0, synd_sync}, 32'd1);
        check({tag, "_synd"}, {s0, s1, s2, s3}, exp);
        check({tag, "_nz"}, {31'd0, nonzero}, {31'd0, exp_nz});
        $display("frame %s: S=%02h %02h %02h %02h nonzero=%0b", tag, s0, s1, s2, s3, nonzero);
    endtask

    task automatic check_idle_after(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_sync_low"}, {31'd0, synd_sync}, 32'd0);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_frame(input string tag, input int gap_max,
                             input logic [31:0] exp, input logic exp_nz);
        send_part(0, N - 1, gap_max);
        check_synd(tag, exp, exp_nz);
        check_idle_after(tag);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        sync_pulses = 0;
        resb  = 1'b0;
        data  = 8'h00;
        valid = 1'b0;
        sof   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_synd", {s0, s1, s2, s3}, 32'h0);
        check("rst_sync", {31'd0, synd_sync}, 32'd0);
        check("rst_nz", {31'd0, nonzero}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        @(negedge clk);
        resb = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-frame: frame dropped without a pulse
        clear_frame();
        frame[N-1] = 8'h01;
        send_part(0, 9, 0);
        check("mid_busy", {31'd0, busy}, 32'd1);
        #2;
        resb = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        resb = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("mid_rst_pulses", sync_pulses, 0);
        run_frame("after_rst", 0, 32'h01010101, 1'b1);
        check("after_rst_pulses", sync_pulses, 1);

        clear_frame();
        run_frame("zero", 2, 32'h00000000, 1'b0);
        check("zero_pulses", sync_pulses, 2);

        // Generator polynomial as the low-order coefficients: a valid codeword
        clear_frame();
        frame[27] = 8'h01; frame[28] = 8'h0F; frame[29] = 8'h36;
        frame[30] = 8'h78; frame[31] = 8'h40;
        run_frame("gen_poly", 1, 32'h00000000, 1'b0);

        clear_frame(); frame[31] = 8'h01;
        run_frame("deg0", 0, 32'h01010101, 1'b1);
        clear_frame(); frame[30] = 8'h01;
        run_frame("deg1", 1, 32'h01020408, 1'b1);
        clear_frame(); frame[29] = 8'h01;
        run_frame("deg2", 0, 32'h01041040, 1'b1);
        clear_frame(); frame[28] = 8'h01;
        run_frame("deg3", 3, 32'h0108403A, 1'b1);

        // Back-to-back: frame A then frame B with no bubble between them
        clear_frame(); frame[29] = 8'h01; frame[31] = 8'h05;
        send_part(0, N - 1, 0);
        check_synd("b2b_a", 32'h04011545, 1'b1);
        clear_frame(); frame[30] = 8'h01;
        send_part(0, 0, 0);
        check("b2b_b_first_sync", {31'd0, synd_sync}, 32'd0);
        check("b2b_b_first_err", {31'd0, frame_err}, 32'd0);
        send_part(1, 15, 3);
        check("b2b_hold_synd", {s0, s1, s2, s3}, 32'h04011545);
        check("b2b_hold_busy", {31'd0, busy}, 32'd1);
        send_part(16, N - 1, 3);
        check_synd("b2b_b", 32'h01020408, 1'b1);
        check_idle_after("b2b_b");
        check("b2b_pulses", sync_pulses, 9);

        // Early SOF aborts the open frame and starts a new one
        clear_frame(); frame[5] = 8'hAA;
        send_part(0, 9, 0);
        clear_frame(); frame[28] = 8'h01;
        send_part(0, 0, 0);
        check("sof_err", {31'd0, frame_err}, 32'd1);
        check("sof_busy", {31'd0, busy}, 32'd1);
        send_part(1, N - 1, 2);
        check_synd("after_sof", 32'h0108403A, 1'b1);
        check_idle_after("after_sof");

        // Stray byte while idle: error pulse, nothing else moves
        send_byte(8'h55, 1'b0);
        check("stray_err", {31'd0, frame_err}, 32'd1);
        check("stray_busy", {31'd0, busy}, 32'd0);
        check("stray_sync", {31'd0, synd_sync}, 32'd0);
        check("stray_synd", {s0, s1, s2, s3}, 32'h0108403A);
        @(posedge clk);
        #1;
        check("stray_err_low", {31'd0, frame_err}, 32'd0);
        check("total_pulses", sync_pulses, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
